// File: rtl/rx_dll_pkg.sv
// Shared types and constants for the DLLP transmit arbiter.
// Holds DLLP type codes, source select enum and arbiter state enum.
package rx_dll_pkg;

    localparam logic [7:0] DLLP_TYPE_ACK = 8'h00;
    localparam logic [7:0] DLLP_TYPE_NAK = 8'h10;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_NAK,
        SRC_ACK,
        SRC_FC
    } dllp_src_e;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } dllp_arb_state_e;

endpackage

// File: rtl/dllp_tx_arbiter_prio_sel.sv
// Combinational winner select for the DLLP transmit arbiter.
// Ports: i_nak_req, i_ack_req, i_fc_req, i_fc_age in; o_src out.
module dllp_prio_sel
    import rx_dll_pkg::*;
#(
    parameter int STARVE_LIMIT = 16
) (
    input  logic       i_nak_req,
    input  logic       i_ack_req,
    input  logic       i_fc_req,
    input  logic [7:0] i_fc_age,
    output dllp_src_e  o_src
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic w_fc_starved;

    // An aged FC request jumps ahead of ACK but never ahead of NAK.
    assign w_fc_starved = i_fc_req & (i_fc_age >= LIMIT);

    always_comb begin
        o_src = SRC_NONE;
        if (i_nak_req) begin
            o_src = SRC_NAK;
        end else if (w_fc_starved) begin
            o_src = SRC_FC;
        end else if (i_ack_req) begin
            o_src = SRC_ACK;
        end else if (i_fc_req) begin
            o_src = SRC_FC;
        end
    end

endmodule

// File: rtl/dllp_tx_arbiter.sv
// Shares one registered 32-bit DLLP channel between NAK, ACK and UpdateFC.
// Ports: clk/reset; nak/ack/fc req,data,grant; dllp_o/valid/ready; dllp_sent_cnt.
module dllp_tx_arbiter
    import rx_dll_pkg::*;
#(
    parameter int STARVE_LIMIT = 16,
    parameter int SEQ_W        = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             nak_req,
    input  logic [SEQ_W-1:0] nak_seq,
    output logic             nak_grant,
    input  logic             ack_req,
    input  logic [SEQ_W-1:0] ack_seq,
    output logic             ack_grant,
    input  logic             fc_req,
    input  logic [31:0]      fc_dllp,
    output logic             fc_grant,
    output logic [31:0]      dllp_o,
    output logic             dllp_valid,
    input  logic             dllp_ready,
    output logic [15:0]      dllp_sent_cnt
);

    dllp_arb_state_e r_state;
    dllp_arb_state_e w_next_state;
    logic [31:0]     r_dllp;
    logic [31:0]     w_payload;
    logic [7:0]      r_fc_age;
    logic [15:0]     r_sent_cnt;
    logic            w_accept;
    logic            w_load;
    dllp_src_e       w_src;
    logic [23:0]     w_nak_ext;
    logic [23:0]     w_ack_ext;

    assign w_nak_ext = 24'(nak_seq);
    assign w_ack_ext = 24'(ack_seq);

    assign w_accept = (r_state == ST_SEND) & dllp_ready;
    // Accept and reload in the same cycle keeps the channel bubble-free.
    assign w_load   = ~reset & ((r_state == ST_IDLE) | w_accept);

    dllp_prio_sel #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio_sel (
        .i_nak_req(nak_req),
        .i_ack_req(ack_req),
        .i_fc_req (fc_req),
        .i_fc_age (r_fc_age),
        .o_src    (w_src)
    );

    always_comb begin
        w_next_state = r_state;
        w_payload    = r_dllp;
        nak_grant    = 1'b0;
        ack_grant    = 1'b0;
        fc_grant     = 1'b0;
        if (w_load) begin
            w_next_state = ST_SEND;
            unique case (w_src)
                SRC_NAK: begin
                    nak_grant = 1'b1;
                    w_payload = {DLLP_TYPE_NAK, w_nak_ext};
                end
                SRC_ACK: begin
                    ack_grant = 1'b1;
                    w_payload = {DLLP_TYPE_ACK, w_ack_ext};
                end
                SRC_FC: begin
                    fc_grant  = 1'b1;
                    w_payload = fc_dllp;
                end
                SRC_NONE: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_dllp     <= 32'h0;
            r_fc_age   <= 8'h0;
            r_sent_cnt <= 16'h0;
        end else begin
            r_state <= w_next_state;
            r_dllp  <= w_payload;
            if (w_accept) begin
                r_sent_cnt <= r_sent_cnt + 16'h1;
            end
            if (!fc_req || fc_grant) begin
                r_fc_age <= 8'h0;
            end else if (r_fc_age != 8'hFF) begin
                r_fc_age <= r_fc_age + 8'h1;
            end
        end
    end

    assign dllp_o        = r_dllp;
    assign dllp_valid    = (r_state == ST_SEND);
    assign dllp_sent_cnt = r_sent_cnt;

endmodule

// File: tb/tb_dllp_tx_arbiter.sv
// Scoreboard bench for dllp_tx_arbiter: directed cases then random traffic.
// Reference model tracks channel occupancy, FC age and accepted count.
module tb_dllp_tx_arbiter;

    logic        clk;
    logic        reset;
    logic        nak_req;
    logic [11:0] nak_seq;
    logic        nak_grant;
    logic        ack_req;
    logic [11:0] ack_seq;
    logic        ack_grant;
    logic        fc_req;
    logic [31:0] fc_dllp;
    logic        fc_grant;
    logic [31:0] dllp_o;
    logic        dllp_valid;
    logic        dllp_ready;
    logic [15:0] dllp_sent_cnt;

    dllp_tx_arbiter #(
        .STARVE_LIMIT(16),
        .SEQ_W       (12)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .nak_req      (nak_req),
        .nak_seq      (nak_seq),
        .nak_grant    (nak_grant),
        .ack_req      (ack_req),
        .ack_seq      (ack_seq),
        .ack_grant    (ack_grant),
        .fc_req       (fc_req),
        .fc_dllp      (fc_dllp),
        .fc_grant     (fc_grant),
        .dllp_o       (dllp_o),
        .dllp_valid   (dllp_valid),
        .dllp_ready   (dllp_ready),
        .dllp_sent_cnt(dllp_sent_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] sb_q[$];

    // Reference model state
    logic        m_valid = 1'b0;
    logic [31:0] m_out   = 32'h0;
    logic        m_fresh = 1'b1;
    logic [15:0] m_cnt   = 16'h0;
    int          m_age   = 0;

    logic gn, ga, gf;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic n, input logic a,
                        input logic f, input logic rdy,
                        input logic [11:0] ns, input logic [11:0] as,
                        input logic [31:0] fd);
        logic        load;
        int          win;
        logic [31:0] pay;
        @(negedge clk);
        reset      = rst;
        nak_req    = n;
        ack_req    = a;
        fc_req     = f;
        dllp_ready = rdy;
        nak_seq    = ns;
        ack_seq    = as;
        fc_dllp    = fd;
        #1;
        chk("valid", 32'(dllp_valid), 32'(m_valid));
        chk("sent_cnt", 32'(dllp_sent_cnt), 32'(m_cnt));
        if (m_valid) chk("held_payload", dllp_o, m_out);
        else if (m_fresh) chk("reset_payload", dllp_o, 32'h0);
        load = !rst && (!m_valid || rdy);
        win  = 0;
        if (n) win = 1;
        else if (f && m_age >= 16) win = 3;
        else if (a) win = 2;
        else if (f) win = 3;
        if (!load) win = 0;
        gn = (win == 1);
        ga = (win == 2);
        gf = (win == 3);
        chk("nak_grant", 32'(nak_grant), 32'(gn));
        chk("ack_grant", 32'(ack_grant), 32'(ga));
        chk("fc_grant", 32'(fc_grant), 32'(gf));
        pay = 32'h0;
        if (win == 1) pay = {8'h10, 12'h000, ns};
        if (win == 2) pay = {8'h00, 12'h000, as};
        if (win == 3) pay = fd;
        if (rst) begin
            m_valid = 1'b0;
            m_out   = 32'h0;
            m_fresh = 1'b1;
            m_cnt   = 16'h0;
            m_age   = 0;
            sb_q.delete();
        end else begin
            if (m_valid && rdy) m_cnt = m_cnt + 16'h1;
            if (load) m_valid = (win != 0);
            if (win != 0) begin
                m_out   = pay;
                m_fresh = 1'b0;
                sb_q.push_back(pay);
            end
            if (!f || gf) m_age = 0;
            else if (m_age < 255) m_age = m_age + 1;
        end
    endtask

    // Monitor: every accepted beat must match the oldest granted payload.
    initial begin
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            #2;
            if (reset === 1'b0 && dllp_valid === 1'b1 &&
                dllp_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow act=%h exp=none", dllp_o);
                end else begin
                    exp = sb_q.pop_front();
                    chk("sb_payload", dllp_o, exp);
                end
            end
        end
    end

    function automatic logic next_req(input logic cur, input logic granted,
                                      input int raise_pct);
        if (cur && !granted && $urandom_range(0, 9) != 0) return 1'b1;
        return ($urandom_range(0, 99) < raise_pct);
    endfunction

    initial begin
        logic n, a, f, r, rs;
        reset      = 1'b1;
        nak_req    = 1'b0;
        ack_req    = 1'b0;
        fc_req     = 1'b0;
        dllp_ready = 1'b0;
        nak_seq    = 12'h0;
        ack_seq    = 12'h0;
        fc_dllp    = 32'h0;
        repeat (2) @(posedge clk);

        // Reset state, then simple ACK
        step(0, 0, 0, 0, 1, 12'h0, 12'h0, 32'h0);
        step(0, 0, 1, 0, 1, 12'h0, 12'h005, 32'h0);
        step(0, 0, 0, 0, 1, 12'h0, 12'h0, 32'h0);
        step(0, 0, 0, 0, 1, 12'h0, 12'h0, 32'h0);

        // NAK beats ACK; ACK loads in the accept cycle
        step(0, 1, 1, 0, 1, 12'h0A0, 12'h011, 32'h0);
        step(0, 0, 1, 0, 1, 12'h0A0, 12'h012, 32'h0);
        step(0, 0, 0, 0, 1, 12'h0, 12'h0, 32'h0);

        // Back-pressure: payload holds, no grants
        step(1, 0, 0, 0, 0, 12'h0, 12'h0, 32'h0);
        step(0, 1, 0, 0, 0, 12'h3C3, 12'h0, 32'h0);
        for (int i = 0; i < 5; i++)
            step(0, 1, 1, 0, 0, 12'h111, 12'(i * 7), 32'h0);
        step(0, 0, 0, 0, 1, 12'h0, 12'h0, 32'h0);
        step(0, 0, 0, 0, 1, 12'h0, 12'h0, 32'h0);

        // FC aging past a continuous ACK stream
        for (int i = 0; i < 24; i++)
            step(0, 0, 1, 1, 1, 12'h0, 12'(i), 32'hCAFE_0000 + 32'(i));
        step(0, 0, 0, 0, 1, 12'h0, 12'h0, 32'h0);

        // Three queued requests drain with no bubble
        step(1, 0, 0, 0, 0, 12'h0, 12'h0, 32'h0);
        step(0, 1, 1, 1, 1, 12'h001, 12'h002, 32'h7777_0003);
        step(0, 0, 1, 1, 1, 12'h0, 12'h002, 32'h7777_0003);
        step(0, 0, 0, 1, 1, 12'h0, 12'h0, 32'h7777_0003);
        step(0, 0, 0, 0, 1, 12'h0, 12'h0, 32'h0);
        step(0, 0, 0, 0, 1, 12'h0, 12'h0, 32'h0);

        // Reset while holding a stalled DLLP
        step(0, 0, 1, 1, 0, 12'h0, 12'h0AA, 32'h1234_5678);
        step(0, 0, 1, 1, 0, 12'h0, 12'h0AB, 32'h1234_5678);
        step(1, 0, 1, 1, 0, 12'h0, 12'h0AB, 32'h1234_5678);
        step(0, 0, 0, 0, 1, 12'h0, 12'h0, 32'h0);

        // Random traffic
        n = 0;
        a = 0;
        f = 0;
        for (int i = 0; i < 4000; i++) begin
            rs = ($urandom_range(0, 499) == 0);
            n  = next_req(n, gn, 10);
            a  = next_req(a, ga, 40);
            f  = next_req(f, gf, 30);
            r  = rs ? 1'b0 : ($urandom_range(0, 9) < 7);
            step(rs, n, a, f, r, 12'($urandom), 12'($urandom),
                 32'($urandom));
        end
        step(0, 0, 0, 0, 1, 12'h0, 12'h0, 32'h0);
        step(0, 0, 0, 0, 1, 12'h0, 12'h0, 32'h0);
        @(negedge clk);
        #3;
        chk("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
